// File: rtl/pwm_bank_pkg.sv
// Shared encodings for the PWM bank register interface.
// Field positions refer to bits of ui_in.
package pwm_bank_pkg;

  typedef enum logic [1:0] {
    REG_DUTY = 2'b00,
    REG_PRE  = 2'b01,
    REG_EN   = 2'b10,
    REG_RSV  = 2'b11
  } reg_sel_e;

  localparam int STB_BIT = 7;
  localparam int SEL_HI  = 6;
  localparam int SEL_LO  = 5;
  localparam int CH_HI   = 2;
  localparam int CH_LO   = 0;
  localparam int CH_W    = CH_HI - CH_LO + 1;

endpackage

// File: rtl/pwm_bank_wr_sync.sv
// Strobe synchroniser and rising-edge detector.
// commit is a single-cycle pulse per strobe assertion.
module pwm_bank_wr_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic commit
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign commit = s2 & ~s3;

endmodule

// File: rtl/tt_um_rk4444_pwm_bank.sv
// Bank of N_CH PWM channels with shared prescaler and period counter.
// Duty is double-buffered and reloaded at each period boundary.
import pwm_bank_pkg::*;

module tt_um_rk4444_pwm_bank #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int PRE_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             commit;
  reg_sel_e         sel;
  logic [CH_W-1:0]  ch;
  logic             wr_duty;
  logic             wr_pre;
  logic             wr_en;

  logic [PRE_W-1:0] pre_reload;
  logic [PRE_W-1:0] pre_cnt;
  logic [N_CH-1:0]  en_mask;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             wrap;
  logic [N_CH-1:0]  pwm;

  pwm_bank_wr_sync u_wr_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (ui_in[STB_BIT]),
    .commit (commit)
  );

  assign sel = reg_sel_e'(ui_in[SEL_HI:SEL_LO]);
  assign ch  = ui_in[CH_HI:CH_LO];

  always_comb begin
    wr_duty = 1'b0;
    wr_pre  = 1'b0;
    wr_en   = 1'b0;
    if (commit) begin
      unique case (1'b1)
        (sel == REG_DUTY): wr_duty = 1'b1;
        (sel == REG_PRE):  wr_pre  = 1'b1;
        (sel == REG_EN):   wr_en   = 1'b1;
        (sel == REG_RSV):  ;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reload <= '0;
      en_mask    <= '0;
    end else begin
      if (wr_pre) pre_reload <= uio_in[PRE_W-1:0];
      if (wr_en)  en_mask    <= uio_in[N_CH-1:0];
    end
  end

  // A reload below the running count lets pre_cnt run on to its natural wrap.
  assign tick = ena & (pre_cnt == pre_reload);
  assign wrap = tick & (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (ena) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] duty_shadow;
    logic [WIDTH-1:0] duty_active;
    logic             pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_shadow <= '0;
        duty_active <= '0;
        pwm_q       <= 1'b0;
      end else begin
        if (wrap) duty_active <= duty_shadow;
        if (wr_duty && (ch == CH_W'(i)))
          duty_shadow <= uio_in[WIDTH-1:0];
        pwm_q <= ena & en_mask[i] & (cnt < duty_active);
      end
    end

    assign pwm[i] = pwm_q;
  end

  always_comb begin
    uo_out         = '0;
    uo_out[N_CH-1:0] = pwm;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

  logic unused;
  assign unused = &{1'b0, ui_in[4:3], uio_in};

endmodule

// File: tb/tb_tt_um_rk4444_pwm_bank.sv
// Bench for the PWM bank: cycle model plus directed waveform checks.
// Inputs change on negedge; the model steps on posedge.
import pwm_bank_pkg::*;

module tb_tt_um_rk4444_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 0;

  tt_um_rk4444_pwm_bank #(.N_CH(4), .WIDTH(8), .PRE_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: integer timebase, duty buffers and write latency.
  int m_pre, m_rel, m_cnt, m_mask;
  int m_sh[4];
  int m_act[4];
  bit h1, h2, h3;
  logic [7:0] exp_out = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0; m_rel = 0; m_cnt = 0; m_mask = 0;
      for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      h1 = 0; h2 = 0; h3 = 0;
      exp_out = '0;
    end else begin
      logic [7:0] nxt;
      bit commit;
      bit tk;
      int c;
      nxt = '0;
      if (ena)
        for (int i = 0; i < 4; i++)
          nxt[i] = ((m_mask >> i) & 1) == 1 && m_cnt < m_act[i];
      commit = h2 && !h3;
      if (ena) begin
        tk = (m_pre == m_rel);
        m_pre = tk ? 0 : (m_pre + 1) % 256;
        if (tk) begin
          if (m_cnt == 255) begin
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
          end else m_cnt = m_cnt + 1;
        end
      end
      if (commit) begin
        c = int'(ui_in[2:0]);
        case (ui_in[6:5])
          2'b00: if (c < 4) m_sh[c] = int'(uio_in);
          2'b01: m_rel = int'(uio_in);
          2'b10: m_mask = int'(uio_in[3:0]);
          default: ;
        endcase
      end
      h3 = h2; h2 = h1; h1 = ui_in[7];
      exp_out = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("uo_out_model", uo_out, exp_out);
      check("uio_zero", {uio_out, uio_oe}, 0);
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [2:0] ch,
                    input logic [7:0] d);
    @(negedge clk);
    ui_in = {1'b0, sel, 2'b00, ch};
    uio_in = d;
    repeat (3) @(negedge clk);
    ui_in[7] = 1'b1;
    repeat (4) @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic count_hi(input int b, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (uo_out[b] === 1'b1) hi++;
    end
  endtask

  task automatic pulse_len(input int b, output int len);
    int t;
    t = 0;
    len = 0;
    while (uo_out[b] !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    while (uo_out[b] !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    while (uo_out[b] === 1'b1 && t < 3000) begin @(negedge clk); len++; t++; end
    if (t >= 3000) check("pulse_timeout", t, 0);
  endtask

  task automatic wait_cnt(input int target);
    int t;
    t = 0;
    while (m_cnt != target && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) check("cnt_wait_timeout", t, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int len;
    int t;

    #2 rst_n = 1'b0;
    #1 chk_on = 1;
    repeat (3) @(negedge clk);
    check("reset_uo_out", uo_out, 0);
    check("reset_uio", {uio_out, uio_oe}, 0);
    rst_n = 1'b1;

    // basic: prescaler 0, duty 64
    wr(REG_PRE, 3'd0, 8'd0);
    wr(REG_DUTY, 3'd0, 8'd64);
    wr(REG_EN, 3'd0, 8'h01);
    repeat (300) @(negedge clk);
    count_hi(0, 256, hi);
    check("basic_hi_ch0", hi, 64);
    count_hi(1, 256, hi);
    check("basic_masked_ch1", hi, 0);
    pulse_len(0, len);
    check("basic_pulse64", len, 64);

    // duty change mid-period lands at next boundary
    wait_cnt(95);
    wr(REG_DUTY, 3'd0, 8'd200);
    check("glitch_low_rest", uo_out[0], 0);
    pulse_len(0, len);
    check("glitch_next200", len, 200);
    pulse_len(0, len);
    check("glitch_again200", len, 200);

    // prescaler 3
    wr(REG_PRE, 3'd0, 8'd3);
    wr(REG_DUTY, 3'd1, 8'd128);
    wr(REG_EN, 3'd0, 8'h02);
    repeat (1100) @(negedge clk);
    count_hi(1, 1024, hi);
    check("pre3_hi512", hi, 512);
    wr(REG_DUTY, 3'd1, 8'd0);
    repeat (1100) @(negedge clk);
    count_hi(1, 1024, hi);
    check("pre3_duty0", hi, 0);
    wr(REG_DUTY, 3'd1, 8'd255);
    repeat (1100) @(negedge clk);
    count_hi(1, 1024, hi);
    check("pre3_duty255_low4", 1024 - hi, 4);

    // held strobe: one write only, later data change ignored
    @(negedge clk);
    ui_in = {1'b0, REG_EN, 2'b00, 3'd0};
    uio_in = 8'h03;
    repeat (3) @(negedge clk);
    ui_in[7] = 1'b1;
    repeat (5) @(negedge clk);
    uio_in = 8'h00;
    repeat (15) @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
    count_hi(0, 1024, hi);
    check("hold_ch0_800", hi, 800);
    count_hi(1, 1024, hi);
    check("hold_ch1_1020", hi, 1020);

    // ignored writes
    wr(REG_DUTY, 3'd5, 8'd10);
    wr(REG_RSV, 3'd0, 8'd0);
    repeat (1100) @(negedge clk);
    count_hi(0, 1024, hi);
    check("ignored_ch0_800", hi, 800);
    count_hi(1, 1024, hi);
    check("ignored_ch1_1020", hi, 1020);

    // ena freeze
    wr(REG_PRE, 3'd0, 8'd0);
    repeat (600) @(negedge clk);
    wait_cnt(50);
    ena = 1'b0;
    count_hi(0, 30, hi);
    check("ena_low_ch0", hi, 0);
    check("ena_low_all", uo_out, 0);
    ena = 1'b1;
    count_hi(0, 256, hi);
    check("ena_resume_200", hi, 200);

    // mask clear
    wr(REG_EN, 3'd0, 8'h01);
    count_hi(1, 256, hi);
    check("mask_clear_ch1", hi, 0);

    // async reset with strobe held across release
    @(negedge clk);
    ui_in = {1'b0, REG_EN, 2'b00, 3'd0};
    uio_in = 8'h01;
    t = 0;
    while (uo_out[0] !== 1'b1 && t < 600) begin @(negedge clk); t++; end
    check("pre_reset_high", uo_out[0], 1);
    ui_in[7] = 1'b1;
    #3 rst_n = 1'b0;
    #1 check("async_reset_uo", uo_out, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_zero", uo_out, 0);
    wr(REG_DUTY, 3'd0, 8'd64);
    repeat (300) @(negedge clk);
    count_hi(0, 256, hi);
    check("held_strobe_write", hi, 64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
